io_bus_bridge: RTL and testbench
================================

# io_bus_bridge

Parametrised memory-mapped I/O bridge between the processor's load/store unit and up to 16 peripherals (UART, timers, GPIO). It replaces the single-cycle, single-peripheral I/O path with a registered request/acknowledge transaction that supports wait states. Each access is decoded to one of N_PORTS channels; the bridge faults on an unmapped or (optionally) timed-out access. It sits between the core's I/O port and the peripheral instances in `system`.

## Interface
- N_PORTS, 4: number of peripheral channels, 1..16
- DATA_W, 32: data width
- ADDR_W, 32: address width
- PORT_SEL_LSB, 12: lowest address bit of the 4-bit port index field
- TIMEOUT, 255: max wait cycles in ACCESS before fault, 1..65535

Ports (one clock; reset is asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_fault  out  1  qualifies cpu_ready: access failed
- p_sel  out  N_PORTS  one-hot channel select
- p_write  out  1  shared write strobe qualifier
- p_addr  out  PORT_SEL_LSB  shared in-peripheral offset
- p_wdata  out  DATA_W  shared write data
- p_rdata  in  N_PORTS*DATA_W  per-channel read data, channel i at [i*DATA_W +: DATA_W]
- p_ack  in  N_PORTS  per-channel completion

## Operation
- States: IDLE, ACCESS, RESP, FAULT.
- IDLE: on cpu_req=1 latch cpu_write, cpu_addr, cpu_wdata; idx = cpu_addr[PORT_SEL_LSB +: 4]. idx < N_PORTS -> ACCESS; else -> FAULT.
- ACCESS: p_sel[idx]=1, p_write/p_addr (cpu_addr[PORT_SEL_LSB-1:0])/p_wdata from latches, held constant. On p_ack[idx]=1: capture channel idx read data (0 for writes) -> RESP.
- RESP: cpu_ready=1, cpu_fault=0, cpu_rdata = captured data; -> IDLE.
- FAULT: cpu_ready=1, cpu_fault=1, cpu_rdata=0; -> IDLE.
- p_ack on non-selected channels and all p_ack outside ACCESS are ignored.
- cpu_req outside IDLE is ignored; requester holds request until cpu_ready.
- Wait counter: cleared on entry to ACCESS, increments each ACCESS cycle without ack; saturates, never wraps.

## Timing
- Reset (async assert): state IDLE, p_sel=0, p_write=0, p_addr=0, p_wdata=0, cpu_ready=0, cpu_fault=0, cpu_rdata=0, counter 0. Reset mid-ACCESS drops p_sel immediately; no cpu_ready for the aborted access.
- Zero-wait access: req sampled edge 0, p_sel high cycle 1, ack in cycle 1, cpu_ready in cycle 2. Latency = 2 + wait cycles.
- Unmapped access: cpu_ready/cpu_fault in cycle 1.
- p_ack may be combinational from p_sel in the same cycle.
- Back-to-back: new req accepted in the IDLE cycle after RESP/FAULT; maximum throughput is one access per 3 cycles.
- All outputs registered.

## Configuration
- IO_BRIDGE_TIMEOUT_EN defined: if the counter reaches TIMEOUT in ACCESS without ack, -> FAULT next edge; ack in the same cycle as the limit wins (RESP).
- Undefined: no counter is instantiated; ACCESS waits indefinitely, and cpu_fault is raised only for unmapped indices.

## Structure
- Package io_bridge_pkg: state enum (IDLE, ACCESS, RESP, FAULT), PORT_IDX_W=4, MAX_PORTS=16.
- Sub-module io_wait_timer (clear, count enable, expired flag, width clog2(TIMEOUT+1)), present only under IO_BRIDGE_TIMEOUT_EN.

## Test plan
- Read port 1, addr 0x0000_1004, peripheral acks immediately with 0xDEADBEEF -> p_sel=4'b0010, p_addr=0x004 in cycle 1; cpu_ready, cpu_rdata=0xDEADBEEF, fault=0 in cycle 2.
- Write port 3, addr 0x3010, data 0x55, ack after 5 waits -> p_sel=4'b1000 held 6 cycles, p_write=1, p_wdata=0x55; cpu_ready in cycle 7.
- Access addr 0x7000 (idx 7, N_PORTS=4) -> no p_sel, cpu_ready=1, cpu_fault=1, rdata=0 in cycle 1.
- TIMEOUT=8 with macro on, no ack -> FAULT after 8 ACCESS cycles; ack arriving in cycle 8 -> normal RESP. With macro off, waits 1000 cycles, then completes on ack.
- Stray p_ack[0] while port 2 is selected, plus cpu_req toggling during ACCESS -> ignored; only port 2's ack completes the access.
- rst_n low mid-ACCESS -> p_sel=0 asynchronously, no cpu_ready; first access after release completes normally.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared types for the I/O bus bridge: FSM state encoding and port index sizing.
// Build option IO_BRIDGE_TIMEOUT_EN enables the ACCESS wait timeout.
package io_bridge_pkg;

    localparam int PORT_IDX_W = 4;
    localparam int MAX_PORTS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FAULT
    } state_e;

endpackage

// File: rtl/io_wait_timer.sv
// Saturating ACCESS wait counter; only built with IO_BRIDGE_TIMEOUT_EN.
// expired is high in the TIMEOUT-th consecutive un-acked ACCESS cycle.
`ifdef IO_BRIDGE_TIMEOUT_EN
module io_wait_timer
    import io_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255,
    localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != SAT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = en && (count >= LAST);

endmodule
`endif

// File: rtl/io_bus_bridge.sv
// Registered request/ack bridge from the LSU to up to 16 peripheral channels.
// IO_BRIDGE_TIMEOUT_EN adds a fault after TIMEOUT un-acked ACCESS cycles.
module io_bus_bridge
    import io_bridge_pkg::*;
#(
    parameter int N_PORTS      = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int PORT_SEL_LSB = 12,
    parameter int TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    input  logic                      cpu_write,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_ready,
    output logic                      cpu_fault,
    output logic [N_PORTS-1:0]        p_sel,
    output logic                      p_write,
    output logic [PORT_SEL_LSB-1:0]   p_addr,
    output logic [DATA_W-1:0]         p_wdata,
    input  logic [N_PORTS*DATA_W-1:0] p_rdata,
    input  logic [N_PORTS-1:0]        p_ack
);

    state_e                state;
    logic [PORT_IDX_W-1:0] idx;
    logic                  mapped;
    logic [N_PORTS-1:0]    sel_dec;
    logic                  ack_sel;
    logic [DATA_W-1:0]     rdata_mux;
    logic                  tmo;
    logic                  unused_addr;

    assign idx     = cpu_addr[PORT_SEL_LSB +: PORT_IDX_W];
    assign mapped  = {1'b0, idx} < (PORT_IDX_W + 1)'(N_PORTS);
    assign sel_dec = N_PORTS'(1) << idx;
    assign unused_addr = ^cpu_addr;

    // p_sel is one-hot, so masking drops acks from unselected channels
    assign ack_sel = |(p_ack & p_sel);

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (p_sel[i]) begin
                rdata_mux |= p_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef IO_BRIDGE_TIMEOUT_EN
    io_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != ACCESS),
        .en     ((state == ACCESS) && !ack_sel),
        .expired(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            p_sel     <= '0;
            p_write   <= 1'b0;
            p_addr    <= '0;
            p_wdata   <= '0;
            cpu_ready <= 1'b0;
            cpu_fault <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        p_write <= cpu_write;
                        p_addr  <= cpu_addr[PORT_SEL_LSB-1:0];
                        p_wdata <= cpu_wdata;
                        if (mapped) begin
                            p_sel <= sel_dec;
                            state <= ACCESS;
                        end else begin
                            cpu_ready <= 1'b1;
                            cpu_fault <= 1'b1;
                            state     <= FAULT;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_sel) begin
                        p_sel     <= '0;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= p_write ? '0 : rdata_mux;
                        state     <= RESP;
                    end else if (tmo) begin
                        p_sel     <= '0;
                        cpu_ready <= 1'b1;
                        cpu_fault <= 1'b1;
                        cpu_rdata <= '0;
                        state     <= FAULT;
                    end
                end
                RESP, FAULT: begin
                    cpu_ready <= 1'b0;
                    cpu_fault <= 1'b0;
                    cpu_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge with a wait-state peripheral model.
// Timeout cases run when IO_BRIDGE_TIMEOUT_EN is defined.
module tb_io_bus_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          start;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_fault;
    logic [3:0]   p_sel;
    logic         p_write;
    logic [11:0]  p_addr;
    logic [31:0]  p_wdata;
    logic [127:0] p_rdata;
    logic [3:0]   p_ack;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   wait_cfg [4];
    int   pcnt [4];
    logic ack_en = 1'b1;
    logic [3:0] stray = '0;
    exp_t sb [$];

    io_bus_bridge #(
        .N_PORTS(4),
        .DATA_W(32),
        .ADDR_W(32),
        .PORT_SEL_LSB(12),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_req(cpu_req),
        .cpu_write(cpu_write),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .cpu_fault(cpu_fault),
        .p_sel(p_sel),
        .p_write(p_write),
        .p_addr(p_addr),
        .p_wdata(p_wdata),
        .p_rdata(p_rdata),
        .p_ack(p_ack)
    );

    always #5 clk = ~clk;

    assign p_rdata = {32'h3333_3333, 32'hCAFE_0002,
                      32'hDEAD_BEEF, 32'h1111_0000};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p_ack[i] = (p_sel[i] && ack_en && pcnt[i] == wait_cfg[i])
                     | stray[i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            pcnt[i] <= (p_sel[i] && !p_ack[i]) ? pcnt[i] + 1 : 0;
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", cpu_rdata, e.rdata);
                chk("fault", cpu_fault, e.fault);
                chk("latency", cyc - e.start, e.lat);
            end
        end
    end

    task automatic access(input logic        wr,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input int          n_acc,
                          input logic [3:0]  exp_sel,
                          input logic        exp_fault,
                          input logic [31:0] exp_rdata,
                          input logic        tog);
        exp_t e;
        logic got;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        e.rdata = exp_rdata;
        e.fault = exp_fault;
        e.lat   = n_acc + 1;
        e.start = cyc;
        sb.push_back(e);
        got = 1'b0;
        for (int j = 1; j <= n_acc + 20 && !got; j++) begin
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1;
                cpu_req = 1'b0;
                chk("sel_done", p_sel, 0);
            end else begin
                if (j == 1 || j == n_acc) begin
                    chk("p_sel", p_sel, exp_sel);
                    if (n_acc > 0) begin
                        chk("p_write", p_write, wr);
                        chk("p_addr", p_addr, addr[11:0]);
                        chk("p_wdata", p_wdata, wdata);
                    end
                end
                if (tog) cpu_req = ~cpu_req;
            end
        end
        if (!got) begin
            chk("ready_timeout", 0, 1);
            cpu_req = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) wait_cfg[i] = 0;
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_p_sel", p_sel, 0);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_fault", cpu_fault, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_p_write", p_write, 0);
        chk("rst_p_addr", p_addr, 0);
        chk("rst_p_wdata", p_wdata, 0);
        rst_n = 1'b1;

        access(1'b0, 32'h0000_1004, 32'h0, 1, 4'b0010,
               1'b0, 32'hDEAD_BEEF, 1'b0);

        wait_cfg[3] = 5;
        access(1'b1, 32'h0000_3010, 32'h55, 6, 4'b1000,
               1'b0, 32'h0, 1'b0);

        access(1'b0, 32'h0000_7000, 32'h0, 0, 4'b0000,
               1'b1, 32'h0, 1'b0);

        wait_cfg[2] = 0;
        access(1'b0, 32'h0000_2008, 32'h0, 1, 4'b0100,
               1'b0, 32'hCAFE_0002, 1'b0);
        access(1'b1, 32'h0000_1ffc, 32'h1234_5678, 1, 4'b0010,
               1'b0, 32'h0, 1'b0);

`ifdef IO_BRIDGE_TIMEOUT_EN
        ack_en = 1'b0;
        access(1'b0, 32'h0000_0020, 32'h0, 8, 4'b0001,
               1'b1, 32'h0, 1'b0);
        ack_en = 1'b1;
        wait_cfg[0] = 7;
        access(1'b0, 32'h0000_0024, 32'h0, 8, 4'b0001,
               1'b0, 32'h1111_0000, 1'b0);
`else
        wait_cfg[0] = 1000;
        access(1'b0, 32'h0000_0020, 32'h0, 1001, 4'b0001,
               1'b0, 32'h1111_0000, 1'b0);
        wait_cfg[0] = 7;
        access(1'b0, 32'h0000_0024, 32'h0, 8, 4'b0001,
               1'b0, 32'h1111_0000, 1'b0);
`endif

        stray = 4'b0001;
        wait_cfg[2] = 3;
        access(1'b0, 32'h0000_2100, 32'h0, 4, 4'b0100,
               1'b0, 32'hCAFE_0002, 1'b1);
        stray = 4'b0000;

        wait_cfg[1] = 20;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 32'h0000_1000;
        repeat (3) @(negedge clk);
        chk("pre_rst_sel", p_sel, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel", p_sel, 0);
        chk("async_ready", cpu_ready, 0);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cfg[1] = 0;
        access(1'b0, 32'h0000_1040, 32'h0, 1, 4'b0010,
               1'b0, 32'hDEAD_BEEF, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
